lcd_timing_rx: RTL and testbench
================================

LCD_TIMING_RX -- requirements
Module: lcd_timing_rx

Interface
REQ-001 SHALL have parameter COLS, default 240; columns (CL2 pulses) per line.
REQ-002 SHALL have parameter ROWS, default 32; lines (CL1 pulses) per frame.
REQ-003 SHALL have parameter M_MAX_FRAMES, default 2; frames allowed without an M toggle before an error.
REQ-004 SHALL have a single clock and synchronous, active-high reset: clk in 1 (system clock, all logic rising-edge); rst in 1 (synchronous, active-high).
REQ-005 SHALL have ports: cl2 in 1 (panel shift clock, async); cl1 in 1 (line latch, async); flm in 1 (first-line marker, async); m in 1 (AC drive, async); d in 4 (pixel nibble, async).
REQ-006 SHALL have ports: pix_valid out 1 (one-cycle strobe per captured nibble); pix_data out 4; pix_col out 8; pix_row out 5.
REQ-007 SHALL have ports: line_done out 1 (one-cycle strobe per CL1); frame_start out 1 (one-cycle strobe when FLM qualifies a line); locked out 1 (high after one clean frame).
REQ-008 SHALL have ports: err_col out 1, err_row out 1, err_m out 1 (sticky error flags); last_cols out 8 (CL2 count of the previous line).

Function
REQ-009 SHALL pass cl2, cl1, flm, m and d through two-flop synchronizers; all decisions use the synchronized copies.
REQ-010 SHALL detect falling edges of synced cl2 and cl1, and any edge of synced m, as one-cycle events.
REQ-011 On a cl2 falling event, SHALL capture synced d into pix_data, present the current column in pix_col and the current row in pix_row, and pulse pix_valid; latency is 3 clk from the raw cl2 fall.
REQ-012 SHALL increment the column counter per cl2 event and saturate it at COLS; a cl2 event at count COLS sets err_col and does not pulse pix_valid.
REQ-013 On a cl1 falling event, SHALL load last_cols with the column count, set err_col if the count is not COLS, clear the column count to 0, and pulse line_done.
REQ-014 If cl2 and cl1 events occur in the same cycle, SHALL capture the pixel first, counting it toward the ending line, then process the line end.
REQ-015 On a cl1 event with synced flm high, SHALL set row to 0 and pulse frame_start; if the previous row count is not ROWS, it SHALL set err_row, except on the first frame after reset.
REQ-016 On a cl1 event with flm low, SHALL increment row; reaching ROWS without flm SHALL set err_row and wrap row to 0.
REQ-017 State machine states SHALL be HUNT, SYNC and LOCK. HUNT ignores pixels until the first frame_start, then goes to SYNC. SYNC goes to LOCK at the next frame_start if no error occurred during the frame, else back to HUNT.
REQ-018 In LOCK, SHALL hold locked = 1; any new err_col or err_row event returns the FSM to HUNT and drops locked.
REQ-019 In HUNT, SHALL suppress pix_valid, line_done and frame_start; counters still run.
REQ-020 SHALL count frame_start events since the last m edge; if the count exceeds M_MAX_FRAMES, it SHALL set err_m.
REQ-021 Error flags SHALL stay set until rst.

Reset
REQ-022 While rst is high, SHALL clear all outputs, counters, synchronizers and error flags to 0, with the FSM in HUNT.
REQ-023 A reset asserted mid-line SHALL discard the partial line; after release, the block waits for a fresh flm-qualified cl1.

Structure
REQ-024 Shared package lcd_pkg SHALL hold COLS/ROWS defaults, the col (8) and row (5) widths, and the FSM state encoding, shared with the timing generator.
REQ-025 Sub-module lcd_sync_edge SHALL implement the 2-flop synchronizer with rise and fall outputs, one instance per control line.

Verification
REQ-026 Drive 2 frames of 240 cl2 per line and 32 cl1 per frame, flm on line 0, m toggling per frame -> locked = 1 after the 2nd frame_start; no errors; 7680 pix_valid in frame 2.
REQ-027 Emit 239 cl2 then cl1 while in LOCK -> last_cols = 239, err_col = 1, locked = 0, FSM in HUNT.
REQ-028 Make the final cl2 fall in the same clk as the cl1 fall -> pix_valid with pix_col = 239, then last_cols = 240, no err_col.
REQ-029 Hold m constant for 3 frames -> err_m = 1 at the 3rd frame_start; other flags remain 0.
REQ-030 Assert rst for 1 cycle at column 100 of row 5 -> all outputs 0; the next pix_valid occurs only after a flm-qualified cl1, with pix_row = 0 and pix_col = 0.
REQ-031 Apply flm on line 20 (short frame) while in LOCK -> err_row = 1, row = 0, locked = 0.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared constants and FSM encoding for the LCD panel timing receiver and generator.
package lcd_pkg;

  localparam int COLS_DEFAULT = 240;
  localparam int ROWS_DEFAULT = 32;
  localparam int COL_W = 8;
  localparam int ROW_W = 5;
  localparam int MCNT_W = 4;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    SYNC = 2'd1,
    LOCK = 2'd2
  } lcd_state_e;

endpackage

// File: rtl/lcd_sync_edge.sv
// Two-flop synchronizer for one asynchronous panel line, with single-cycle edge strobes.
module lcd_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_o = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/lcd_timing_rx.sv
// Receives a raw STN panel interface (CL2/CL1/FLM/M/D), counts columns and rows, and tracks lock.
module lcd_timing_rx
  import lcd_pkg::*;
#(
  parameter int COLS         = COLS_DEFAULT,
  parameter int ROWS         = ROWS_DEFAULT,
  parameter int M_MAX_FRAMES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cl2,
  input  logic             cl1,
  input  logic             flm,
  input  logic             m,
  input  logic [3:0]       d,
  output logic             pix_valid,
  output logic [3:0]       pix_data,
  output logic [COL_W-1:0] pix_col,
  output logic [ROW_W-1:0] pix_row,
  output logic             line_done,
  output logic             frame_start,
  output logic             locked,
  output logic             err_col,
  output logic             err_row,
  output logic             err_m,
  output logic [COL_W-1:0] last_cols
);

  localparam logic [COL_W-1:0] COLS_C   = COL_W'(COLS);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  logic cl2Sync, cl2Rise, cl2Fall;
  logic cl1Sync, cl1Rise, cl1Fall;
  logic flmSync, flmRise, flmFall;
  logic mSync, mRise, mFall;
  logic unused_edges;

  lcd_sync_edge uCl2 (.clk(clk), .rst(rst), .async_i(cl2), .sync_o(cl2Sync), .rise_o(cl2Rise), .fall_o(cl2Fall));
  lcd_sync_edge uCl1 (.clk(clk), .rst(rst), .async_i(cl1), .sync_o(cl1Sync), .rise_o(cl1Rise), .fall_o(cl1Fall));
  lcd_sync_edge uFlm (.clk(clk), .rst(rst), .async_i(flm), .sync_o(flmSync), .rise_o(flmRise), .fall_o(flmFall));
  lcd_sync_edge uM   (.clk(clk), .rst(rst), .async_i(m),   .sync_o(mSync),   .rise_o(mRise),   .fall_o(mFall));

  assign unused_edges = ^{cl2Sync, cl2Rise, cl1Sync, cl1Rise, flmRise, flmFall, mSync};

  logic [3:0]        dMeta_q, dSync_q;
  logic [COL_W-1:0]  col_q, col_d, colEnd;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  lastCols_q, lastCols_d;
  logic              pixValid_q, pixValid_d;
  logic [3:0]        pixData_q, pixData_d;
  logic [COL_W-1:0]  pixCol_q, pixCol_d;
  logic [ROW_W-1:0]  pixRow_q, pixRow_d;
  logic              lineDone_q, lineDone_d;
  logic              frameStart_q, frameStart_d;
  logic              errCol_q, errCol_d;
  logic              errRow_q, errRow_d;
  logic              errM_q, errM_d;
  logic              seenFrame_q, seenFrame_d;
  logic [MCNT_W-1:0] mCnt_q, mCnt_d, mBase;
  logic              errColEv, errRowEv, errEv, frameEv, active, mEdge;
  lcd_state_e        state_q;
  logic              frameErr_q;
  logic              locked_q;

  // Pixel is counted before the line end so a coincident CL2/CL1 belongs to the ending line.
  // Error checks wait for the first FLM so a line cut by reset is not judged.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    lastCols_d   = lastCols_q;
    pixValid_d   = 1'b0;
    pixData_d    = pixData_q;
    pixCol_d     = pixCol_q;
    pixRow_d     = pixRow_q;
    lineDone_d   = 1'b0;
    frameStart_d = 1'b0;
    seenFrame_d  = seenFrame_q;
    colEnd       = col_q;
    errColEv     = 1'b0;
    errRowEv     = 1'b0;
    frameEv      = 1'b0;
    active       = (state_q != HUNT);
    mEdge        = mRise | mFall;

    if (cl2Fall) begin
      if (col_q == COLS_C) begin
        errColEv = seenFrame_q;
      end else begin
        pixValid_d = active;
        pixData_d  = dSync_q;
        pixCol_d   = col_q;
        pixRow_d   = row_q;
        colEnd     = col_q + COL_W'(1);
      end
    end
    col_d = colEnd;

    if (cl1Fall) begin
      lastCols_d = colEnd;
      col_d      = '0;
      lineDone_d = active;
      if (colEnd != COLS_C && seenFrame_q) errColEv = 1'b1;
      if (flmSync) begin
        frameEv      = 1'b1;
        row_d        = '0;
        frameStart_d = active;
        seenFrame_d  = 1'b1;
        if (seenFrame_q && row_q != ROW_LAST) errRowEv = 1'b1;
      end else if (row_q == ROW_LAST) begin
        row_d    = '0;
        errRowEv = seenFrame_q;
      end else begin
        row_d = row_q + ROW_W'(1);
      end
    end

    errEv    = errColEv | errRowEv;
    errCol_d = errCol_q | errColEv;
    errRow_d = errRow_q | errRowEv;

    mBase  = mEdge ? '0 : mCnt_q;
    mCnt_d = mBase;
    errM_d = errM_q;
    if (frameEv) begin
      if (mBase != '1) mCnt_d = mBase + MCNT_W'(1);
      if (int'(mBase) + 1 > M_MAX_FRAMES) errM_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dMeta_q      <= '0;
      dSync_q      <= '0;
      col_q        <= '0;
      row_q        <= '0;
      lastCols_q   <= '0;
      pixValid_q   <= 1'b0;
      pixData_q    <= '0;
      pixCol_q     <= '0;
      pixRow_q     <= '0;
      lineDone_q   <= 1'b0;
      frameStart_q <= 1'b0;
      errCol_q     <= 1'b0;
      errRow_q     <= 1'b0;
      errM_q       <= 1'b0;
      seenFrame_q  <= 1'b0;
      mCnt_q       <= '0;
    end else begin
      dMeta_q      <= d;
      dSync_q      <= dMeta_q;
      col_q        <= col_d;
      row_q        <= row_d;
      lastCols_q   <= lastCols_d;
      pixValid_q   <= pixValid_d;
      pixData_q    <= pixData_d;
      pixCol_q     <= pixCol_d;
      pixRow_q     <= pixRow_d;
      lineDone_q   <= lineDone_d;
      frameStart_q <= frameStart_d;
      errCol_q     <= errCol_d;
      errRow_q     <= errRow_d;
      errM_q       <= errM_d;
      seenFrame_q  <= seenFrame_d;
      mCnt_q       <= mCnt_d;
    end
  end

  // A frame in SYNC only earns LOCK if it closes without any column or row error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HUNT;
      frameErr_q <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      case (state_q)
        HUNT: begin
          locked_q <= 1'b0;
          if (frameEv) begin
            state_q    <= SYNC;
            frameErr_q <= 1'b0;
          end
        end
        SYNC: begin
          if (frameEv) begin
            state_q    <= (frameErr_q || errEv) ? HUNT : LOCK;
            locked_q   <= !(frameErr_q || errEv);
            frameErr_q <= 1'b0;
          end else if (errEv) begin
            frameErr_q <= 1'b1;
          end
        end
        LOCK: begin
          if (errEv) begin
            state_q  <= HUNT;
            locked_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= HUNT;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

  assign pix_valid   = pixValid_q;
  assign pix_data    = pixData_q;
  assign pix_col     = pixCol_q;
  assign pix_row     = pixRow_q;
  assign line_done   = lineDone_q;
  assign frame_start = frameStart_q;
  assign locked      = locked_q;
  assign err_col     = errCol_q;
  assign err_row     = errRow_q;
  assign err_m       = errM_q;
  assign last_cols   = lastCols_q;

endmodule

// File: tb/tb_lcd_timing_rx.sv
// Directed bench for lcd_timing_rx: lock-up, line/frame errors, M watchdog and reset recovery.
module tb_lcd_timing_rx;
  import lcd_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cl2 = 1'b0;
  logic       cl1 = 1'b0;
  logic       flm = 1'b0;
  logic       m   = 1'b0;
  logic [3:0] d   = 4'h0;

  logic       pix_valid;
  logic [3:0] pix_data;
  logic [7:0] pix_col;
  logic [4:0] pix_row;
  logic       line_done, frame_start, locked, err_col, err_row, err_m;
  logic [7:0] last_cols;

  int total = 0;
  int bad = 0;

  int         pixCount = 0;
  int         bothCount = 0;
  int         frameStartCount = 0;
  logic [7:0] lastPixCol = 8'h0;
  logic [4:0] lastPixRow = 5'h0;
  logic [3:0] lastPixData = 4'h0;

  lcd_timing_rx dut (
    .clk(clk), .rst(rst), .cl2(cl2), .cl1(cl1), .flm(flm), .m(m), .d(d),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_col(pix_col), .pix_row(pix_row),
    .line_done(line_done), .frame_start(frame_start), .locked(locked),
    .err_col(err_col), .err_row(err_row), .err_m(err_m), .last_cols(last_cols)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pix_valid) begin
      pixCount++;
      lastPixCol = pix_col;
      lastPixRow = pix_row;
      lastPixData = pix_data;
      if (line_done) bothCount++;
    end
    if (frame_start) frameStartCount++;
  end

  initial begin
    #1500000;
    $display("[TB] FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  task automatic sendPixels(input int n, input logic [3:0] base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      cl2 = 1'b1;
      d = base + 4'(i);
      @(posedge clk); #1;
      cl2 = 1'b0;
    end
  endtask

  task automatic pulseCl1(input logic f);
    @(posedge clk); #1;
    cl1 = 1'b1;
    flm = f;
    @(posedge clk); #1;
    cl1 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flm = 1'b0;
  endtask

  task automatic flush();
    repeat (6) @(posedge clk);
    #2;
  endtask

  task automatic runFrame(input int firstLine);
    for (int r = 0; r < 32; r++) begin
      sendPixels((r == 0) ? firstLine : 240, 4'(r));
      if (r != 31) pulseCl1(1'b0);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    if ({pix_valid, pix_data, pix_col, pix_row, line_done, frame_start, locked,
         err_col, err_row, err_m, last_cols} !== 34'h0) begin
      $display("[TB] FAIL reset_outputs: got %0h expected 0",
               {pix_valid, pix_data, pix_col, pix_row, line_done, frame_start, locked,
                err_col, err_row, err_m, last_cols});
      bad++;
    end
    total++;
    if (dut.state_q !== HUNT) begin
      $display("[TB] FAIL reset_state: got %0d expected %0d", dut.state_q, HUNT);
      bad++;
    end
    total++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_midline_reset();
    int snap;
    pulseCl1(1'b1);
    for (int l = 0; l < 5; l++) begin
      sendPixels(240, 4'h0);
      pulseCl1(1'b0);
    end
    sendPixels(100, 4'h0);
    flush();
    if (last_cols !== 8'd240) begin
      $display("[TB] FAIL pre_reset_last_cols: got %0d expected 240", last_cols);
      bad++;
    end
    total++;
    if (lastPixRow !== 5'd5 || lastPixCol !== 8'd99) begin
      $display("[TB] FAIL pre_reset_position: got row %0d col %0d expected row 5 col 99",
               lastPixRow, lastPixCol);
      bad++;
    end
    total++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    if ({pix_valid, pix_data, pix_col, pix_row, line_done, frame_start, locked,
         err_col, err_row, err_m, last_cols} !== 34'h0) begin
      $display("[TB] FAIL midline_reset_outputs: got %0h expected 0",
               {pix_valid, pix_data, pix_col, pix_row, line_done, frame_start, locked,
                err_col, err_row, err_m, last_cols});
      bad++;
    end
    total++;
    rst = 1'b0;
    snap = pixCount;
    sendPixels(20, 4'h3);
    flush();
    if (pixCount !== snap) begin
      $display("[TB] FAIL hunt_suppress: got %0d pixels expected 0", pixCount - snap);
      bad++;
    end
    total++;
    pulseCl1(1'b1);
    sendPixels(1, 4'hA);
    flush();
    if (pixCount !== snap + 1) begin
      $display("[TB] FAIL first_pixel_count: got %0d expected 1", pixCount - snap);
      bad++;
    end
    total++;
    if (lastPixRow !== 5'd0 || lastPixCol !== 8'd0 || lastPixData !== 4'hA) begin
      $display("[TB] FAIL first_pixel: got row %0d col %0d data %0h expected row 0 col 0 data a",
               lastPixRow, lastPixCol, lastPixData);
      bad++;
    end
    total++;
  endtask

  task automatic test_m_stuck();
    int fsSnap;
    fsSnap = frameStartCount;
    runFrame(239);
    pulseCl1(1'b1);
    flush();
    if (locked !== 1'b1 || err_m !== 1'b0) begin
      $display("[TB] FAIL m_second_frame: got locked %0b err_m %0b expected 1 0", locked, err_m);
      bad++;
    end
    total++;
    runFrame(240);
    pulseCl1(1'b1);
    flush();
    if (err_m !== 1'b1) begin
      $display("[TB] FAIL m_stuck_err: got %0b expected 1", err_m);
      bad++;
    end
    total++;
    if (err_col !== 1'b0 || err_row !== 1'b0 || locked !== 1'b1) begin
      $display("[TB] FAIL m_stuck_others: got col %0b row %0b locked %0b expected 0 0 1",
               err_col, err_row, locked);
      bad++;
    end
    total++;
    if (frameStartCount - fsSnap !== 2) begin
      $display("[TB] FAIL m_stuck_frame_starts: got %0d expected 2", frameStartCount - fsSnap);
      bad++;
    end
    total++;
  endtask

  task automatic test_short_line();
    sendPixels(239, 4'h0);
    pulseCl1(1'b0);
    flush();
    if (last_cols !== 8'd239) begin
      $display("[TB] FAIL short_line_last_cols: got %0d expected 239", last_cols);
      bad++;
    end
    total++;
    if (err_col !== 1'b1 || locked !== 1'b0) begin
      $display("[TB] FAIL short_line_flags: got err_col %0b locked %0b expected 1 0", err_col, locked);
      bad++;
    end
    total++;
    if (dut.state_q !== HUNT) begin
      $display("[TB] FAIL short_line_state: got %0d expected %0d", dut.state_q, HUNT);
      bad++;
    end
    total++;
  endtask

  task automatic test_full_frames();
    int snap;
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    if ({err_col, err_row, err_m, locked} !== 4'h0) begin
      $display("[TB] FAIL rereset_flags: got %0h expected 0", {err_col, err_row, err_m, locked});
      bad++;
    end
    total++;
    pulseCl1(1'b1);
    m = ~m;
    runFrame(240);
    pulseCl1(1'b1);
    flush();
    if (locked !== 1'b1) begin
      $display("[TB] FAIL lock_after_second_frame: got %0b expected 1", locked);
      bad++;
    end
    total++;
    m = ~m;
    snap = pixCount;
    runFrame(240);
    flush();
    if (pixCount - snap !== 7680) begin
      $display("[TB] FAIL frame_pixel_count: got %0d expected 7680", pixCount - snap);
      bad++;
    end
    total++;
    pulseCl1(1'b1);
    flush();
    if ({err_col, err_row, err_m} !== 3'b000 || locked !== 1'b1) begin
      $display("[TB] FAIL clean_frames: got errs %0b locked %0b expected 000 1",
               {err_col, err_row, err_m}, locked);
      bad++;
    end
    total++;
    if (last_cols !== 8'd240) begin
      $display("[TB] FAIL clean_last_cols: got %0d expected 240", last_cols);
      bad++;
    end
    total++;
  endtask

  task automatic test_coincident();
    int snapBoth;
    sendPixels(239, 4'h0);
    snapBoth = bothCount;
    @(posedge clk); #1;
    cl2 = 1'b1;
    cl1 = 1'b1;
    d = 4'h5;
    @(posedge clk); #1;
    cl2 = 1'b0;
    cl1 = 1'b0;
    flush();
    if (bothCount - snapBoth !== 1) begin
      $display("[TB] FAIL coincident_strobes: got %0d expected 1", bothCount - snapBoth);
      bad++;
    end
    total++;
    if (lastPixCol !== 8'd239 || lastPixData !== 4'h5) begin
      $display("[TB] FAIL coincident_pixel: got col %0d data %0h expected col 239 data 5",
               lastPixCol, lastPixData);
      bad++;
    end
    total++;
    if (last_cols !== 8'd240 || err_col !== 1'b0) begin
      $display("[TB] FAIL coincident_line: got last_cols %0d err_col %0b expected 240 0",
               last_cols, err_col);
      bad++;
    end
    total++;
  endtask

  task automatic test_short_frame();
    for (int i = 1; i < 20; i++) begin
      sendPixels(240, 4'h0);
      pulseCl1(i == 19);
    end
    flush();
    if (err_row !== 1'b1 || locked !== 1'b0) begin
      $display("[TB] FAIL short_frame_flags: got err_row %0b locked %0b expected 1 0", err_row, locked);
      bad++;
    end
    total++;
    if (dut.row_q !== 5'd0) begin
      $display("[TB] FAIL short_frame_row: got %0d expected 0", dut.row_q);
      bad++;
    end
    total++;
    if (err_col !== 1'b0) begin
      $display("[TB] FAIL short_frame_err_col: got %0b expected 0", err_col);
      bad++;
    end
    total++;
  endtask

  initial begin
    test_reset();
    test_midline_reset();
    test_m_stuck();
    test_short_line();
    test_full_frames();
    test_coincident();
    test_short_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
